writeback_arbiter: RTL and testbench

Collects the registered per-unit results of the execute stage (ALU, load/store, branch) and serializes them onto a single writeback bus to the physical register file and ROB. Each unit has a small FIFO, so a cycle where all three units finish together loses no result; a round-robin arbiter drains one entry per cycle. It sits directly downstream of the issue/execute stage and upstream of the PRF write port and the ROB completion logic.

---
 rtl/writeback_arbiter_if.sv | 82 ++++++++
 rtl/writeback_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_writeback_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_arbiter_if.sv
// ---------------------------------------------------------------------------
// writeback_arbiter_if
//
// Bundles the execute-stage result channels (ALU, load/store, branch), the
// pipeline flush, and the serialized writeback bus into one interface.
//
//   master modport : execute stage / environment side. Drives flush and the
//                    three result channels, observes the writeback bus,
//                    the per-channel full flags and overflow_err.
//   slave modport  : writeback_arbiter side. The mirror image.
//
// Channel signals:
//   alu_valid/alu_rob_id/alu_rd_phy/alu_data        ALU result
//   ls_valid/ls_rob_id/ls_rd_phy/ls_data/ls_is_store load/store completion
//   br_valid/br_rob_id/br_rd_phy/br_next_pc/
//   br_jump_pc/br_is_jump                           branch completion
// Writeback bus:
//   wb_valid, wb_rob_id, wb_rd_phy, wb_data, wb_reg_we,
//   wb_is_branch, wb_jump_pc, wb_is_jump
// Status:
//   alu_full, ls_full, br_full, overflow_err
// ---------------------------------------------------------------------------
interface writeback_arbiter_if #(
  parameter int ROB_WIDTH  = 5,
  parameter int PHY_WIDTH  = 6,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  flush;

  logic                  alu_valid;
  logic [ROB_WIDTH-1:0]  alu_rob_id;
  logic [PHY_WIDTH-1:0]  alu_rd_phy;
  logic [DATA_WIDTH-1:0] alu_data;

  logic                  ls_valid;
  logic [ROB_WIDTH-1:0]  ls_rob_id;
  logic [PHY_WIDTH-1:0]  ls_rd_phy;
  logic [DATA_WIDTH-1:0] ls_data;
  logic                  ls_is_store;

  logic                  br_valid;
  logic [ROB_WIDTH-1:0]  br_rob_id;
  logic [PHY_WIDTH-1:0]  br_rd_phy;
  logic [ADDR_WIDTH-1:0] br_next_pc;
  logic [ADDR_WIDTH-1:0] br_jump_pc;
  logic                  br_is_jump;

  logic                  wb_valid;
  logic [ROB_WIDTH-1:0]  wb_rob_id;
  logic [PHY_WIDTH-1:0]  wb_rd_phy;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  wb_reg_we;
  logic                  wb_is_branch;
  logic [ADDR_WIDTH-1:0] wb_jump_pc;
  logic                  wb_is_jump;

  logic                  alu_full;
  logic                  ls_full;
  logic                  br_full;
  logic                  overflow_err;

  modport master (
    output flush,
    output alu_valid, alu_rob_id, alu_rd_phy, alu_data,
    output ls_valid, ls_rob_id, ls_rd_phy, ls_data, ls_is_store,
    output br_valid, br_rob_id, br_rd_phy, br_next_pc, br_jump_pc, br_is_jump,
    input  wb_valid, wb_rob_id, wb_rd_phy, wb_data, wb_reg_we,
    input  wb_is_branch, wb_jump_pc, wb_is_jump,
    input  alu_full, ls_full, br_full, overflow_err
  );

  modport slave (
    input  flush,
    input  alu_valid, alu_rob_id, alu_rd_phy, alu_data,
    input  ls_valid, ls_rob_id, ls_rd_phy, ls_data, ls_is_store,
    input  br_valid, br_rob_id, br_rd_phy, br_next_pc, br_jump_pc, br_is_jump,
    output wb_valid, wb_rob_id, wb_rd_phy, wb_data, wb_reg_we,
    output wb_is_branch, wb_jump_pc, wb_is_jump,
    output alu_full, ls_full, br_full, overflow_err
  );
endinterface

// File: rtl/writeback_arbiter.sv
// ---------------------------------------------------------------------------
// writeback_arbiter
//
// Collects execute-stage results from three channels (0 = ALU, 1 = LS,
// 2 = BR), buffers each in its own small circular FIFO, and serializes them
// onto one registered writeback bus with a round-robin arbiter (one entry
// per cycle).
//
// Ports:
//   clk    : clock
//   rst    : asynchronous active-high reset
//   wb_bus : writeback_arbiter_if.slave -- flush, three result channels,
//            writeback bus, per-channel full flags, sticky overflow_err
//
// Optional feature (macro WB_BYPASS_EN):
//   When defined, a channel whose FIFO is empty may present its incoming
//   result directly to the arbiter; if granted it goes straight into the
//   output register (one edge of latency) and is not pushed.
// ---------------------------------------------------------------------------
module writeback_arbiter #(
  parameter int ROB_WIDTH  = 5,
  parameter int PHY_WIDTH  = 6,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic                clk,
  input logic                rst,
  writeback_arbiter_if.slave wb_bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Normalised writeback entry. reg_we is resolved at capture time so the
  // FIFOs and output register never need to know the source channel.
  typedef struct packed {
    logic [ROB_WIDTH-1:0]  rob_id;
    logic [PHY_WIDTH-1:0]  rd_phy;
    logic [DATA_WIDTH-1:0] data;
    logic                  reg_we;
    logic                  is_branch;
    logic [ADDR_WIDTH-1:0] jump_pc;
    logic                  is_jump;
  } wb_entry_t;

  typedef enum logic [1:0] {
    RR_ALU = 2'd0,
    RR_LS  = 2'd1,
    RR_BR  = 2'd2
  } rr_state_t;

  rr_state_t rr_ptr_reg, rr_ptr_next;

  logic [2:0] in_valid;      // channel valids, masked by flush
  wb_entry_t  in_entry [3];
  wb_entry_t  head     [3];
  logic [2:0] fifo_full, fifo_empty;
  logic [2:0] cand, push, pop, drop, bypass_take;
  logic       grant_any;
  logic [1:0] grant_idx;
  logic [2:0] slot;
  wb_entry_t  sel_entry;

  logic       wb_valid_reg;
  wb_entry_t  wb_entry_reg;
  logic       overflow_reg;

  // Inputs seen during a flush are discarded outright.
  assign in_valid = {wb_bus.br_valid, wb_bus.ls_valid, wb_bus.alu_valid}
                    & {3{~wb_bus.flush}};

  always_comb begin
    in_entry[0] = '0;
    in_entry[1] = '0;
    in_entry[2] = '0;

    in_entry[0].rob_id = wb_bus.alu_rob_id;
    in_entry[0].rd_phy = wb_bus.alu_rd_phy;
    in_entry[0].data   = wb_bus.alu_data;
    in_entry[0].reg_we = (wb_bus.alu_rd_phy != '0);

    in_entry[1].rob_id = wb_bus.ls_rob_id;
    in_entry[1].rd_phy = wb_bus.ls_rd_phy;
    in_entry[1].data   = wb_bus.ls_data;
    in_entry[1].reg_we = !wb_bus.ls_is_store && (wb_bus.ls_rd_phy != '0);

    // Branches write the link value (next_pc) to the destination register.
    in_entry[2].rob_id    = wb_bus.br_rob_id;
    in_entry[2].rd_phy    = wb_bus.br_rd_phy;
    in_entry[2].data      = DATA_WIDTH'(wb_bus.br_next_pc);
    in_entry[2].reg_we    = (wb_bus.br_rd_phy != '0);
    in_entry[2].is_branch = 1'b1;
    in_entry[2].jump_pc   = wb_bus.br_jump_pc;
    in_entry[2].is_jump   = wb_bus.br_is_jump;
  end

  // ---------------------------------------------------------------------
  // Per-channel circular FIFOs. Storage is not reset; only pointers and
  // counts are. Pointers wrap naturally since the depth is a power of two.
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_fifo
    logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    wb_entry_t        mem [FIFO_DEPTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        count_reg  <= '0;
      end else if (wb_bus.flush) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        case ({push[gi], pop[gi]})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (push[gi]) mem[wr_ptr_reg] <= in_entry[gi];
    end

    assign head[gi]       = mem[rd_ptr_reg];
    assign fifo_full[gi]  = (count_reg == CNT_W'(FIFO_DEPTH));
    assign fifo_empty[gi] = (count_reg == '0);
  end

  // ---------------------------------------------------------------------
  // Round-robin grant, pop/push/drop decisions and output-entry select.
  // ---------------------------------------------------------------------
  always_comb begin
    cand = ~fifo_empty;
`ifdef WB_BYPASS_EN
    // An empty FIFO with a live input can compete directly.
    cand = ~fifo_empty | in_valid;
`endif

    grant_any = 1'b0;
    grant_idx = 2'd0;
    slot      = 3'd0;
    for (int i = 0; i < 3; i++) begin
      slot = {1'b0, rr_ptr_reg} + 3'(i);
      if (slot >= 3'd3) slot = slot - 3'd3;
      if (!grant_any && cand[slot[1:0]]) begin
        grant_any = 1'b1;
        grant_idx = slot[1:0];
      end
    end
    if (wb_bus.flush) grant_any = 1'b0;

    pop         = '0;
    push        = '0;
    drop        = '0;
    bypass_take = '0;
    for (int k = 0; k < 3; k++) begin
      pop[k] = grant_any && (grant_idx == 2'(k)) && !fifo_empty[k];
`ifdef WB_BYPASS_EN
      bypass_take[k] = grant_any && (grant_idx == 2'(k)) && fifo_empty[k];
`endif
      // A full FIFO still accepts a push when its head leaves this cycle.
      push[k] = in_valid[k] && !bypass_take[k] && (!fifo_full[k] || pop[k]);
      drop[k] = in_valid[k] && fifo_full[k] && !pop[k];
    end

    case (grant_idx)
      2'd1:    sel_entry = bypass_take[1] ? in_entry[1] : head[1];
      2'd2:    sel_entry = bypass_take[2] ? in_entry[2] : head[2];
      default: sel_entry = bypass_take[0] ? in_entry[0] : head[0];
    endcase
  end

  // Round-robin pointer: move just past the granted channel, else hold.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant_any) begin
      case (grant_idx)
        2'd0:    rr_ptr_next = RR_LS;
        2'd1:    rr_ptr_next = RR_BR;
        default: rr_ptr_next = RR_ALU;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg <= RR_ALU;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  // ---------------------------------------------------------------------
  // Output register and sticky overflow flag. Payload is zeroed whenever
  // no entry is being written back.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_reg <= 1'b0;
      wb_entry_reg <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wb_valid_reg <= grant_any;
      wb_entry_reg <= grant_any ? sel_entry : '0;
      overflow_reg <= overflow_reg | (|drop);
    end
  end

  assign wb_bus.wb_valid     = wb_valid_reg;
  assign wb_bus.wb_rob_id    = wb_entry_reg.rob_id;
  assign wb_bus.wb_rd_phy    = wb_entry_reg.rd_phy;
  assign wb_bus.wb_data      = wb_entry_reg.data;
  assign wb_bus.wb_reg_we    = wb_entry_reg.reg_we;
  assign wb_bus.wb_is_branch = wb_entry_reg.is_branch;
  assign wb_bus.wb_jump_pc   = wb_entry_reg.jump_pc;
  assign wb_bus.wb_is_jump   = wb_entry_reg.is_jump;

  assign wb_bus.alu_full     = fifo_full[0];
  assign wb_bus.ls_full      = fifo_full[1];
  assign wb_bus.br_full      = fifo_full[2];
  assign wb_bus.overflow_err = overflow_reg;

endmodule

// File: tb/tb_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// tb_writeback_arbiter
//
// Directed stimulus for writeback_arbiter (default build). Each stimulus
// step pushes its hand-computed writeback(s), with the expected cycle, into
// a scoreboard queue; an independent monitor pops and compares on every
// wb_valid. Status flags are checked directly by the stimulus process.
// ---------------------------------------------------------------------------
module tb_writeback_arbiter;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_pass;

  typedef struct {
    logic [4:0]  rob;
    logic [5:0]  rd;
    logic [31:0] data;
    logic        we;
    logic        br;
    logic [31:0] jpc;
    logic        jmp;
    int          at_cyc;
  } exp_t;

  exp_t sb[$];
  int   ov_order [19];

  writeback_arbiter_if #(
    .ROB_WIDTH(5), .PHY_WIDTH(6), .DATA_WIDTH(32), .ADDR_WIDTH(32)
  ) bus ();

  writeback_arbiter #(
    .ROB_WIDTH(5), .PHY_WIDTH(6), .DATA_WIDTH(32), .ADDR_WIDTH(32),
    .FIFO_DEPTH(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wb_bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [4:0] rob, input logic [5:0] rd,
                              input logic [31:0] data, input logic we,
                              input logic br, input logic [31:0] jpc,
                              input logic jmp, input int at_cyc);
    exp_t e;
    e.rob = rob; e.rd = rd; e.data = data; e.we = we;
    e.br = br; e.jpc = jpc; e.jmp = jmp; e.at_cyc = at_cyc;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  // Monitor: one line per writeback transaction.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && bus.wb_valid) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL stray_wb: cyc=%0d got rob=%0d rd=%0d data=%h, expected no writeback",
                 cyc, bus.wb_rob_id, bus.wb_rd_phy, bus.wb_data);
      end else begin
        e = sb.pop_front();
        if (bus.wb_rob_id === e.rob && bus.wb_rd_phy === e.rd &&
            bus.wb_data === e.data && bus.wb_reg_we === e.we &&
            bus.wb_is_branch === e.br && bus.wb_jump_pc === e.jpc &&
            bus.wb_is_jump === e.jmp && cyc == e.at_cyc) begin
          n_pass++;
          $display("wb cyc=%0d rob=%0d rd=%0d data=%h we=%b br=%b jpc=%h jmp=%b ok",
                   cyc, bus.wb_rob_id, bus.wb_rd_phy, bus.wb_data,
                   bus.wb_reg_we, bus.wb_is_branch, bus.wb_jump_pc, bus.wb_is_jump);
        end else begin
          $display("FAIL wb_txn: got cyc=%0d rob=%0d rd=%0d data=%h we=%b br=%b jpc=%h jmp=%b, expected cyc=%0d rob=%0d rd=%0d data=%h we=%b br=%b jpc=%h jmp=%b",
                   cyc, bus.wb_rob_id, bus.wb_rd_phy, bus.wb_data, bus.wb_reg_we,
                   bus.wb_is_branch, bus.wb_jump_pc, bus.wb_is_jump,
                   e.at_cyc, e.rob, e.rd, e.data, e.we, e.br, e.jpc, e.jmp);
        end
      end
    end
  end

  task automatic idle();
    bus.flush = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_rob_id = '0; bus.alu_rd_phy = '0; bus.alu_data = '0;
    bus.ls_valid = 1'b0; bus.ls_rob_id = '0; bus.ls_rd_phy = '0; bus.ls_data = '0;
    bus.ls_is_store = 1'b0;
    bus.br_valid = 1'b0; bus.br_rob_id = '0; bus.br_rd_phy = '0; bus.br_next_pc = '0;
    bus.br_jump_pc = '0; bus.br_is_jump = 1'b0;
  endtask

  task automatic drv_alu(input int rob, input int rd, input logic [31:0] data);
    bus.alu_valid = 1'b1; bus.alu_rob_id = 5'(rob); bus.alu_rd_phy = 6'(rd);
    bus.alu_data = data;
  endtask

  task automatic drv_ls(input int rob, input int rd, input logic [31:0] data,
                        input logic st);
    bus.ls_valid = 1'b1; bus.ls_rob_id = 5'(rob); bus.ls_rd_phy = 6'(rd);
    bus.ls_data = data; bus.ls_is_store = st;
  endtask

  task automatic drv_br(input int rob, input int rd, input logic [31:0] npc,
                        input logic [31:0] jpc, input logic jmp);
    bus.br_valid = 1'b1; bus.br_rob_id = 5'(rob); bus.br_rd_phy = 6'(rd);
    bus.br_next_pc = npc; bus.br_jump_pc = jpc; bus.br_is_jump = jmp;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  // Wait (bounded) for every expected writeback, then idle a few cycles so
  // the monitor can catch any extra pulse.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    int r;
    cyc = 0; n_checks = 0; n_pass = 0;
    rst = 1'b1;
    idle();
    ov_order = '{0, 8, 16, 1, 9, 17, 2, 10, 18, 3, 11, 19, 4, 12, 20, 5, 13, 22, 7};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    check("rst_wb_data", 64'(bus.wb_data), 64'd0);
    check("rst_alu_full", 64'(bus.alu_full), 64'd0);
    check("rst_br_full", 64'(bus.br_full), 64'd0);
    check("rst_overflow", 64'(bus.overflow_err), 64'd0);
    rst = 1'b0;

    // Single ALU result: visible one cycle after its push edge.
    @(negedge clk);
    base = cyc;
    drv_alu(3, 7, 32'hDEADBEEF);
    sb.push_back(mk(5'd3, 6'd7, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 1'b0, base + 2));
    @(negedge clk);
    idle();
    drain("single_alu");

    // Three-way collision from reset: ALU, LS, BR on consecutive cycles.
    do_reset();
    @(negedge clk);
    base = cyc;
    drv_alu(1, 1, 32'h11);
    drv_ls(2, 2, 32'h22, 1'b0);
    drv_br(3, 3, 32'h100, 32'h200, 1'b1);
    sb.push_back(mk(5'd1, 6'd1, 32'h11, 1'b1, 1'b0, 32'h0, 1'b0, base + 2));
    sb.push_back(mk(5'd2, 6'd2, 32'h22, 1'b1, 1'b0, 32'h0, 1'b0, base + 3));
    sb.push_back(mk(5'd3, 6'd3, 32'h100, 1'b1, 1'b1, 32'h200, 1'b1, base + 4));
    @(negedge clk);
    idle();
    drain("collision");
    // rr_ptr is back at ALU: ALU beats BR when both arrive together.
    @(negedge clk);
    base = cyc;
    drv_alu(4, 4, 32'h44);
    drv_br(5, 6, 32'h104, 32'h300, 1'b0);
    sb.push_back(mk(5'd4, 6'd4, 32'h44, 1'b1, 1'b0, 32'h0, 1'b0, base + 2));
    sb.push_back(mk(5'd5, 6'd6, 32'h104, 1'b1, 1'b1, 32'h300, 1'b0, base + 3));
    @(negedge clk);
    idle();
    drain("rr_after_collision");

    // Store, x0 destination, ordinary load.
    @(negedge clk);
    base = cyc;
    drv_ls(6, 5, 32'h55, 1'b1);
    sb.push_back(mk(5'd6, 6'd5, 32'h55, 1'b0, 1'b0, 32'h0, 1'b0, base + 2));
    @(negedge clk);
    idle();
    drain("store");
    @(negedge clk);
    base = cyc;
    drv_alu(7, 0, 32'h77);
    sb.push_back(mk(5'd7, 6'd0, 32'h77, 1'b0, 1'b0, 32'h0, 1'b0, base + 2));
    @(negedge clk);
    idle();
    drain("alu_x0");
    @(negedge clk);
    base = cyc;
    drv_ls(8, 9, 32'h88, 1'b0);
    sb.push_back(mk(5'd8, 6'd9, 32'h88, 1'b1, 1'b0, 32'h0, 1'b0, base + 2));
    @(negedge clk);
    idle();
    drain("load");

    // Overflow: all three valid for 8 cycles. Hand-derived grant order
    // (rob ids) runs one writeback per cycle from base+2.
    do_reset();
    base = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin
        base = cyc;
        for (int k = 0; k < 19; k++) begin
          r = ov_order[k];
          if (r < 8)
            sb.push_back(mk(5'(r), 6'(r + 1), 32'hA000_0000 + 32'(r), 1'b1, 1'b0, 32'h0, 1'b0, base + 2 + k));
          else if (r < 16)
            sb.push_back(mk(5'(r), 6'(r + 1), 32'hB000_0000 + 32'(r), 1'b1, 1'b0, 32'h0, 1'b0, base + 2 + k));
          else
            sb.push_back(mk(5'(r), 6'(r + 1), 32'h1000 + 32'(r * 4), 1'b1, 1'b1,
                            32'h2000 + 32'(r * 4), r[0], base + 2 + k));
        end
      end
      if (i == 4) check("br_full_before", 64'(bus.br_full), 64'd0);
      if (i == 5) begin
        check("br_full_set", 64'(bus.br_full), 64'd1);
        check("overflow_before_drop", 64'(bus.overflow_err), 64'd0);
      end
      if (i == 6) check("overflow_on_drop", 64'(bus.overflow_err), 64'd1);
      drv_alu(i, i + 1, 32'hA000_0000 + 32'(i));
      drv_ls(8 + i, 9 + i, 32'hB000_0000 + 32'(8 + i), 1'b0);
      drv_br(16 + i, 17 + i, 32'h1000 + 32'((16 + i) * 4), 32'h2000 + 32'((16 + i) * 4),
             1'(i & 1));
    end
    @(negedge clk);
    idle();
    drain("overflow");
    check("overflow_sticky", 64'(bus.overflow_err), 64'd1);
    check("br_full_drained", 64'(bus.br_full), 64'd0);

    // Flush mid-drain: two ALU entries queued, flush right as the first
    // appears; an ALU input in the flush cycle is discarded.
    do_reset();
    @(negedge clk);
    base = cyc;
    drv_alu(9, 9, 32'h99);
    sb.push_back(mk(5'd9, 6'd9, 32'h99, 1'b1, 1'b0, 32'h0, 1'b0, base + 2));
    @(negedge clk);
    drv_alu(10, 10, 32'hAA);
    @(negedge clk);
    drv_alu(11, 11, 32'hBB);
    bus.flush = 1'b1;
    @(negedge clk);
    idle();
    check("flush_wb_valid", 64'(bus.wb_valid), 64'd0);
    check("flush_alu_full", 64'(bus.alu_full), 64'd0);
    check("flush_no_overflow", 64'(bus.overflow_err), 64'd0);
    drain("flush");
    @(negedge clk);
    base = cyc;
    drv_alu(12, 12, 32'hCC);
    sb.push_back(mk(5'd12, 6'd12, 32'hCC, 1'b1, 1'b0, 32'h0, 1'b0, base + 2));
    @(negedge clk);
    idle();
    drain("after_flush");

    // Asynchronous reset while a writeback is on the bus.
    do_reset();
    @(negedge clk);
    base = cyc;
    drv_alu(13, 13, 32'hD0);
    drv_ls(14, 14, 32'hD1, 1'b0);
    drv_br(15, 15, 32'hD2, 32'hD3, 1'b1);
    sb.push_back(mk(5'd13, 6'd13, 32'hD0, 1'b1, 1'b0, 32'h0, 1'b0, base + 2));
    @(negedge clk);
    idle();
    @(negedge clk);
    #2;
    check("pre_rst_wb_valid", 64'(bus.wb_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("async_rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    check("async_rst_wb_rob", 64'(bus.wb_rob_id), 64'd0);
    check("async_rst_wb_data", 64'(bus.wb_data), 64'd0);
    check("async_rst_wb_we", 64'(bus.wb_reg_we), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    base = cyc;
    drv_ls(16, 16, 32'hE0, 1'b0);
    drv_alu(17, 17, 32'hE1);
    sb.push_back(mk(5'd17, 6'd17, 32'hE1, 1'b1, 1'b0, 32'h0, 1'b0, base + 2));
    sb.push_back(mk(5'd16, 6'd16, 32'hE0, 1'b1, 1'b0, 32'h0, 1'b0, base + 3));
    @(negedge clk);
    idle();
    drain("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
